// File: rtl/time_entry_loader.sv
// time_entry_loader
//
// Keypad-side writer for the timer's BCD down-counter load interface. Collects
// up to MAX_DIGITS decimal key presses into an M:SS shift buffer, validates the
// seconds-tens digit on ENTER, and issues a one-cycle active-low load strobe
// with the three BCD nibbles to the downstream counter chain.
//
// Optional build macro:
//   KEY_EDGE_DETECT_EN - digit_valid is treated as a level; a digit is accepted
//                        only on a 0->1 transition of the registered digit_valid
//                        (one extra cycle of latency).
//
// Ports:
//   clk            in   system clock, rising edge
//   clear          in   asynchronous active-high reset
//   digit_valid    in   digit strobe
//   digit[3:0]     in   key code, 0-9 legal
//   enter          in   commit request pulse
//   cancel         in   abort request pulse
//   loadn          out  active-low load strobe
//   data_sec_ones  out  load value, seconds ones
//   data_sec_tens  out  load value, seconds tens
//   data_min_ones  out  load value, minutes ones
//   entering       out  high while an entry is in progress
//   count[1:0]     out  digits currently buffered
//   err            out  one-cycle pulse on a rejected action

module time_entry_loader #(
    parameter int unsigned MAX_SEC_TENS = 5,
    parameter int unsigned MAX_DIGITS   = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       enter,
    input  logic       cancel,
    output logic       loadn,
    output logic [3:0] data_sec_ones,
    output logic [3:0] data_sec_tens,
    output logic [3:0] data_min_ones,
    output logic       entering,
    output logic [1:0] count,
    output logic       err
);

    localparam logic [1:0] MaxCount = 2'(MAX_DIGITS);
    localparam logic [3:0] MaxTens  = 4'(MAX_SEC_TENS);

    typedef enum logic [1:0] {StIdle, StEntry, StLoad} state_e;

    state_e     state;
    logic       key_stb;
    logic [3:0] key_code;
    logic       key_legal;

`ifdef KEY_EDGE_DETECT_EN
    logic       dv_q;
    logic       dv_qq;
    logic [3:0] digit_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            dv_q    <= 1'b0;
            dv_qq   <= 1'b0;
            digit_q <= 4'h0;
        end else begin
            dv_q    <= digit_valid;
            dv_qq   <= dv_q;
            digit_q <= digit;
        end
    end

    // Rising edge of the registered level; the code travels with it.
    assign key_stb  = dv_q & ~dv_qq;
    assign key_code = digit_q;
`else
    assign key_stb  = digit_valid;
    assign key_code = digit;
`endif

    assign key_legal = (key_code <= 4'd9);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state         <= StIdle;
            loadn         <= 1'b1;
            data_sec_ones <= 4'h0;
            data_sec_tens <= 4'h0;
            data_min_ones <= 4'h0;
            entering      <= 1'b0;
            count         <= 2'd0;
            err           <= 1'b0;
        end else begin
            err   <= 1'b0;
            loadn <= 1'b1;
            unique case (state)
                StIdle: begin
                    // cancel has no effect here but still masks enter/digit.
                    if (cancel) begin
                        state <= StIdle;
                    end else if (enter) begin
                        err <= 1'b1;
                    end else if (key_stb) begin
                        if (key_legal) begin
                            // Shifts into whatever the last load left behind.
                            data_min_ones <= data_sec_tens;
                            data_sec_tens <= data_sec_ones;
                            data_sec_ones <= key_code;
                            count         <= 2'd1;
                            state         <= StEntry;
                            entering      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StEntry: begin
                    if (cancel) begin
                        data_min_ones <= 4'h0;
                        data_sec_tens <= 4'h0;
                        data_sec_ones <= 4'h0;
                        count         <= 2'd0;
                        state         <= StIdle;
                        entering      <= 1'b0;
                    end else if (enter) begin
                        if (data_sec_tens > MaxTens) begin
                            err <= 1'b1;
                        end else begin
                            state    <= StLoad;
                            loadn    <= 1'b0;
                            entering <= 1'b0;
                        end
                    end else if (key_stb) begin
                        if (!key_legal || count == MaxCount) begin
                            err <= 1'b1;
                        end else begin
                            data_min_ones <= data_sec_tens;
                            data_sec_tens <= data_sec_ones;
                            data_sec_ones <= key_code;
                            count         <= count + 2'd1;
                        end
                    end
                end
                StLoad: begin
                    // Inputs are ignored; data nibbles are retained.
                    state <= StIdle;
                    count <= 2'd0;
                end
                default: begin
                    state    <= StIdle;
                    entering <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_entry_loader.sv
module tb_time_entry_loader;

    localparam int unsigned MaxTens = 5;
    localparam int unsigned MaxDig  = 3;

    logic       clk = 1'b0;
    logic       clear;
    logic       digit_valid;
    logic [3:0] digit;
    logic       enter;
    logic       cancel;
    logic       loadn;
    logic [3:0] data_sec_ones;
    logic [3:0] data_sec_tens;
    logic [3:0] data_min_ones;
    logic       entering;
    logic [1:0] count;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    time_entry_loader #(
        .MAX_SEC_TENS(MaxTens),
        .MAX_DIGITS  (MaxDig)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .digit_valid  (digit_valid),
        .digit        (digit),
        .enter        (enter),
        .cancel       (cancel),
        .loadn        (loadn),
        .data_sec_ones(data_sec_ones),
        .data_sec_tens(data_sec_tens),
        .data_min_ones(data_min_ones),
        .entering     (entering),
        .count        (count),
        .err          (err)
    );

    // Output bundle: {loadn, min_ones, sec_tens, sec_ones, entering, count, err}
    typedef struct {
        logic        dv;
        logic [3:0]  dg;
        logic        en;
        logic        ca;
        logic [16:0] exp;
    } vec_t;

    function automatic logic [16:0] pack(input logic ld, input int mo, input int st,
                                         input int so, input logic ent, input int cnt,
                                         input logic er);
        return {ld, 4'(mo), 4'(st), 4'(so), ent, 2'(cnt), er};
    endfunction

    function automatic vec_t mk(input logic dv, input int dg, input logic en, input logic ca,
                                input logic ld, input int mo, input int st, input int so,
                                input logic ent, input int cnt, input logic er);
        vec_t v;
        v.dv  = dv;
        v.dg  = 4'(dg);
        v.en  = en;
        v.ca  = ca;
        v.exp = pack(ld, mo, st, so, ent, cnt, er);
        return v;
    endfunction

    function automatic logic [16:0] obs();
        return {loadn, data_min_ones, data_sec_tens, data_sec_ones, entering, count, err};
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got loadn=%b data=%h ent=%b cnt=%0d err=%b, want loadn=%b data=%h ent=%b cnt=%0d err=%b",
                     name, act[16], act[15:4], act[3], act[2:1], act[0],
                     exp[16], exp[15:4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    // Reference model: the buffer is a 3-digit decimal number, shifting is *10.
    int   m_val;
    int   m_n;
    bit   m_entry;
    bit   m_loading;
    bit   m_err;
    bit   m_loadn;
    bit   m_dv1;
    bit   m_dv2;
    int   m_dg1;

    function automatic void model_reset();
        m_val = 0; m_n = 0; m_entry = 0; m_loading = 0; m_err = 0; m_loadn = 1;
        m_dv1 = 0; m_dv2 = 0; m_dg1 = 0;
    endfunction

    function automatic void model_step(input bit dv, input int dg, input bit en, input bit ca);
        bit stb;
        int code;
`ifdef KEY_EDGE_DETECT_EN
        stb   = m_dv1 && !m_dv2;
        code  = m_dg1;
        m_dv2 = m_dv1;
        m_dv1 = dv;
        m_dg1 = dg;
`else
        stb  = dv;
        code = dg;
`endif
        m_err   = 0;
        m_loadn = 1;
        if (m_loading) begin
            m_loading = 0;
            m_n       = 0;
        end else if (ca) begin
            if (m_entry) begin
                m_val = 0; m_n = 0; m_entry = 0;
            end
        end else if (en) begin
            if (!m_entry || ((m_val / 10) % 10) > int'(MaxTens)) m_err = 1;
            else begin
                m_loading = 1; m_entry = 0; m_loadn = 0;
            end
        end else if (stb) begin
            if (code > 9 || m_n == int'(MaxDig)) m_err = 1;
            else begin
                m_val   = (m_val % 100) * 10 + code;
                m_n     = m_n + 1;
                m_entry = 1;
            end
        end
    endfunction

    function automatic logic [16:0] model_out();
        return pack(m_loadn, m_val / 100, (m_val / 10) % 10, m_val % 10, m_entry, m_n, m_err);
    endfunction

    task automatic apply(input logic dv, input logic [3:0] dg, input logic en, input logic ca);
        digit_valid = dv; digit = dg; enter = en; cancel = ca;
        @(posedge clk);
        #1;
        digit_valid = 1'b0; enter = 1'b0; cancel = 1'b0;
    endtask

    task automatic do_reset();
        clear = 1'b1;
        digit_valid = 1'b0; digit = 4'h0; enter = 1'b0; cancel = 1'b0;
        @(posedge clk);
        #1;
        check("reset", obs(), pack(1, 0, 0, 0, 0, 0, 0));
        clear = 1'b0;
        model_reset();
    endtask

    vec_t tbl[$];

    initial begin
        do_reset();

`ifndef KEY_EDGE_DETECT_EN
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0, 1, 0, 1, 3, 1, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 3, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3, 0, 0, 3, 0));  // load 1:30
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 0, 0, 1, 3, 0, 7, 1, 1, 0));  // shifts into retained data
        tbl.push_back(mk(1, 2, 0, 0, 1, 0, 7, 2, 1, 2, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 7, 2, 1, 2, 1));  // tens 7 rejected
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));  // cancel
        tbl.push_back(mk(1, 4, 0, 0, 1, 0, 0, 4, 1, 1, 0));
        tbl.push_back(mk(1, 5, 0, 0, 1, 0, 4, 5, 1, 2, 0));
        tbl.push_back(mk(1, 6, 0, 0, 1, 4, 5, 6, 1, 3, 0));
        tbl.push_back(mk(1, 9, 0, 0, 1, 4, 5, 6, 1, 3, 1));  // buffer full
        tbl.push_back(mk(0, 0, 1, 0, 0, 4, 5, 6, 0, 3, 0));  // load 4:56
        tbl.push_back(mk(0, 0, 0, 0, 1, 4, 5, 6, 0, 0, 0));
        tbl.push_back(mk(1, 12, 0, 0, 1, 4, 5, 6, 0, 0, 1)); // illegal in idle
        tbl.push_back(mk(0, 0, 1, 0, 1, 4, 5, 6, 0, 0, 1));  // enter in idle
        tbl.push_back(mk(0, 0, 0, 0, 1, 4, 5, 6, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 1, 1, 4, 5, 6, 0, 0, 0));  // cancel wins in idle
        tbl.push_back(mk(1, 1, 0, 0, 1, 5, 6, 1, 1, 1, 0));
        tbl.push_back(mk(1, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0));  // cancel wins in entry
        tbl.push_back(mk(1, 2, 0, 0, 1, 0, 0, 2, 1, 1, 0));
        tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 2, 0, 1, 0));  // enter beats digit
        tbl.push_back(mk(1, 5, 1, 0, 1, 0, 0, 2, 0, 0, 0));  // ignored during load
        tbl.push_back(mk(1, 14, 0, 0, 1, 0, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1, 3, 0, 0, 1, 0, 2, 3, 1, 1, 0));
        tbl.push_back(mk(1, 10, 0, 0, 1, 0, 2, 3, 1, 1, 1)); // illegal in entry

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].dv, tbl[i].dg, tbl[i].en, tbl[i].ca);
            check($sformatf("table[%0d]", i), obs(), tbl[i].exp);
        end

        // clear during the LOAD cycle
        do_reset();
        apply(1, 4'd1, 0, 0);
        apply(1, 4'd2, 0, 0);
        apply(0, 4'd0, 1, 0);
        check("load_strobe", obs(), pack(0, 0, 1, 2, 0, 2, 0));
        #2 clear = 1'b1;
        #1 check("clear_in_load", obs(), pack(1, 0, 0, 0, 0, 0, 0));
        #1 clear = 1'b0;
        apply(0, 4'd0, 0, 0);
        check("after_clear", obs(), pack(1, 0, 0, 0, 0, 0, 0));
`else
        // Held key accepts exactly one digit
        digit_valid = 1'b1; digit = 4'd8;
        repeat (5) @(posedge clk);
        #1 digit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("held_key", obs(), pack(1, 0, 0, 8, 1, 1, 0));
`endif

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 500; i++) begin
            logic dv;
            logic [3:0] dg;
            logic en;
            logic ca;
            dv = ($urandom_range(0, 2) != 0);
            dg = 4'($urandom_range(0, 11));
            en = ($urandom_range(0, 5) == 0);
            ca = ($urandom_range(0, 11) == 0);
            apply(dv, dg, en, ca);
            model_step(dv, int'(dg), en, ca);
            check($sformatf("rand[%0d]", i), obs(), model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
